// File: rtl/emu_video_pkg.sv
// emu_video_pkg: shared types and helpers for the emu raster timing generator.
package emu_video_pkg;

   typedef enum logic [1:0] {
      ORIGINAL = 2'd0,
      NTSC     = 2'd1,
      CUSTOM   = 2'd2,
      RSVD     = 2'd3
   } adj_mode_e;

   // 0 means no shift; 1..15 maps to -7..+7
   function automatic logic signed [4:0] vpos_offset(input logic [3:0] vpos);
      return (vpos == 4'd0) ? 5'sd0 : $signed({1'b0, vpos}) - 5'sd8;
   endfunction

endpackage

// File: rtl/emu_pxcen_div.sv
// emu_pxcen_div: divides the master clock into a one-MCLK pixel enable.
// o_PXCEN_PRE is high in the cycle before o_PXCEN so the counters can step on the same edge.
module emu_pxcen_div #(
   parameter int DIV = 10
) (
   input  logic i_EMU_MCLK,
   input  logic i_EMU_RST_n,
   output logic o_PXCEN,
   output logic o_PXCEN_PRE
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [DW-1:0] r_div;
   logic          r_pxcen;

   assign o_PXCEN_PRE = (r_div == DW'(DIV - 1));
   assign o_PXCEN     = r_pxcen;

   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         r_div   <= '0;
         r_pxcen <= 1'b0;
      end else begin
         r_div   <= o_PXCEN_PRE ? '0 : r_div + 1'b1;
         r_pxcen <= o_PXCEN_PRE;
      end
   end

endmodule

// File: rtl/emu_video_timing.sv
// emu_video_timing: raster timing generator with H/V counters, sync/blank decode,
// refresh-mode, vertical sync shift and flip all latched at frame boundaries.
module emu_video_timing
   import emu_video_pkg::*;
#(
   parameter int PXCEN_DIV    = 10,
   parameter int CNT_W        = 9,
   parameter int H_TOTAL      = 384,
   parameter int H_ACTIVE     = 256,
   parameter int HSYNC_START  = 288,
   parameter int HSYNC_WIDTH  = 32,
   parameter int V_TOTAL      = 272,
   parameter int V_ACTIVE     = 224,
   parameter int VSYNC_START  = 240,
   parameter int VSYNC_WIDTH  = 4,
   parameter int NTSC_V_TOTAL = 262
) (
   input  logic             i_EMU_MCLK,
   input  logic             i_EMU_RST_n,
   input  logic             i_FLIP,
   input  logic [1:0]       i_ADJ_MODE,
   input  logic [1:0]       i_ADJ_H,
   input  logic [2:0]       i_ADJ_V,
   input  logic [3:0]       i_VPOS_ADJ,
   output logic             o_PXCEN,
   output logic [CNT_W-1:0] o_HCNTR,
   output logic [CNT_W-1:0] o_VCNTR,
   output logic             o_HSYNC_n,
   output logic             o_VSYNC_n,
   output logic             o_HBLANK_n,
   output logic             o_VBLANK_n,
   output logic             o_FRAME_START
);

   // the shifted vsync window must stay inside the blanking region of every mode
   if (VSYNC_START < V_ACTIVE + 7 ||
       VSYNC_START + VSYNC_WIDTH + 7 > V_TOTAL ||
       VSYNC_START + VSYNC_WIDTH + 7 > NTSC_V_TOTAL ||
       H_TOTAL + 6 >= 2**CNT_W ||
       V_TOTAL + 7 >= 2**CNT_W) begin : g_param_chk
      $error("emu_video_timing: illegal timing parameters");
   end

   logic w_adv;

   emu_pxcen_div #(.DIV(PXCEN_DIV)) u_div (
      .i_EMU_MCLK  (i_EMU_MCLK),
      .i_EMU_RST_n (i_EMU_RST_n),
      .o_PXCEN     (o_PXCEN),
      .o_PXCEN_PRE (w_adv)
   );

   adj_mode_e        r_mode;
   logic [1:0]       r_adj_h;
   logic [2:0]       r_adj_v;
   logic [3:0]       r_vpos;
   logic             r_flip;
   logic [CNT_W-1:0] r_hcnt, r_vcnt, r_hout, r_vout;
   logic             r_hs_n, r_vs_n, r_hb_n, r_vb_n, r_fs;

   logic [CNT_W-1:0] w_ht, w_vt, w_hnxt, w_vnxt;
   logic             w_hend, w_vend, w_frame, w_flip_n, w_hact, w_vact, w_hsync, w_vsync;
   logic signed [4:0]     w_off;
   logic signed [CNT_W:0] w_vs, w_ve, w_vn;

   assign w_ht = (r_mode == CUSTOM) ? CNT_W'(H_TOTAL) + CNT_W'({r_adj_h, 1'b0}) : CNT_W'(H_TOTAL);
   assign w_vt = (r_mode == NTSC)   ? CNT_W'(NTSC_V_TOTAL) :
                 (r_mode == CUSTOM) ? CNT_W'(V_TOTAL) + CNT_W'(r_adj_v) : CNT_W'(V_TOTAL);

   assign w_hend  = (r_hcnt == w_ht - 1'b1);
   assign w_vend  = (r_vcnt == w_vt - 1'b1);
   assign w_frame = w_hend && w_vend;
   assign w_hnxt  = w_hend ? '0 : r_hcnt + 1'b1;
   assign w_vnxt  = !w_hend ? r_vcnt : w_vend ? '0 : r_vcnt + 1'b1;

   // the first pixel of a new frame already shows the newly latched flip
   assign w_flip_n = w_frame ? i_FLIP : r_flip;

   assign w_hact  = (w_hnxt < CNT_W'(H_ACTIVE));
   assign w_vact  = (w_vnxt < CNT_W'(V_ACTIVE));
   assign w_hsync = ({1'b0, w_hnxt} >= (CNT_W+1)'(HSYNC_START)) &&
                    ({1'b0, w_hnxt} <  (CNT_W+1)'(HSYNC_START + HSYNC_WIDTH));

   assign w_off   = vpos_offset(r_vpos);
   assign w_vs    = $signed((CNT_W+1)'(VSYNC_START)) + $signed({{(CNT_W-4){w_off[4]}}, w_off});
   assign w_ve    = w_vs + $signed((CNT_W+1)'(VSYNC_WIDTH));
   assign w_vn    = $signed({1'b0, w_vnxt});
   assign w_vsync = (w_vn >= w_vs) && (w_vn < w_ve);

   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         r_hcnt  <= '0;
         r_vcnt  <= '0;
         r_hout  <= '0;
         r_vout  <= '0;
         r_hs_n  <= 1'b1;
         r_vs_n  <= 1'b1;
         r_hb_n  <= 1'b0;
         r_vb_n  <= 1'b0;
         r_fs    <= 1'b0;
         r_mode  <= ORIGINAL;
         r_adj_h <= '0;
         r_adj_v <= '0;
         r_vpos  <= '0;
         r_flip  <= 1'b0;
      end else begin
         r_fs <= w_adv && w_frame;
         if (w_adv) begin
            r_hcnt <= w_hnxt;
            r_vcnt <= w_vnxt;
            r_hout <= (w_flip_n && w_hact && w_vact) ? CNT_W'(H_ACTIVE - 1) - w_hnxt : w_hnxt;
            r_vout <= (w_flip_n && w_hact && w_vact) ? CNT_W'(V_ACTIVE - 1) - w_vnxt : w_vnxt;
            r_hs_n <= !w_hsync;
            r_vs_n <= !w_vsync;
            r_hb_n <= w_hact;
            r_vb_n <= w_vact;
            if (w_frame) begin
               r_mode  <= adj_mode_e'(i_ADJ_MODE);
               r_adj_h <= i_ADJ_H;
               r_adj_v <= i_ADJ_V;
               r_vpos  <= i_VPOS_ADJ;
               r_flip  <= i_FLIP;
            end
         end
      end
   end

   assign o_HCNTR       = r_hout;
   assign o_VCNTR       = r_vout;
   assign o_HSYNC_n     = r_hs_n;
   assign o_VSYNC_n     = r_vs_n;
   assign o_HBLANK_n    = r_hb_n;
   assign o_VBLANK_n    = r_vb_n;
   assign o_FRAME_START = r_fs;

endmodule

// File: tb/tb_emu_video_timing.sv
// tb_emu_video_timing: directed checks of emu_video_timing on a shrunken raster
// (16x22 pixels, divide by 3) so whole frames fit in a short run.
module tb_emu_video_timing;

   localparam int DIV = 3, CW = 6;

   logic          clk = 1'b0, rst_n = 1'b0, flip = 1'b0;
   logic [1:0]    mode = '0, adj_h = '0;
   logic [2:0]    adj_v = '0;
   logic [3:0]    vpos = '0;
   logic          o_PXCEN, o_HSYNC_n, o_VSYNC_n, o_HBLANK_n, o_VBLANK_n, o_FRAME_START;
   logic [CW-1:0] o_HCNTR, o_VCNTR;

   int n_chk = 0, n_fail = 0;
   int per, hmax, vmax, hs_first, hs_len, vs_first, vs_len, vb_len, hb_len;
   int n, m, k;

   emu_video_timing #(
      .PXCEN_DIV(DIV), .CNT_W(CW), .H_TOTAL(16), .H_ACTIVE(8), .HSYNC_START(10),
      .HSYNC_WIDTH(2), .V_TOTAL(22), .V_ACTIVE(4), .VSYNC_START(12), .VSYNC_WIDTH(2),
      .NTSC_V_TOTAL(21)
   ) dut (
      .i_EMU_MCLK(clk), .i_EMU_RST_n(rst_n), .i_FLIP(flip), .i_ADJ_MODE(mode),
      .i_ADJ_H(adj_h), .i_ADJ_V(adj_v), .i_VPOS_ADJ(vpos), .o_PXCEN(o_PXCEN),
      .o_HCNTR(o_HCNTR), .o_VCNTR(o_VCNTR), .o_HSYNC_n(o_HSYNC_n), .o_VSYNC_n(o_VSYNC_n),
      .o_HBLANK_n(o_HBLANK_n), .o_VBLANK_n(o_VBLANK_n), .o_FRAME_START(o_FRAME_START)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // walks from one frame-start sample to the next, collecting raster statistics
   task automatic scan();
      per = 0; hmax = 0; vmax = 0; hs_first = -1; hs_len = 0;
      vs_first = -1; vs_len = 0; vb_len = 0; hb_len = 0;
      do begin
         @(negedge clk);
         per++;
         if (o_PXCEN) begin
            if (int'(o_HCNTR) > hmax) hmax = int'(o_HCNTR);
            if (int'(o_VCNTR) > vmax) vmax = int'(o_VCNTR);
            if (o_VCNTR == 0 && !o_HSYNC_n) begin
               if (hs_len == 0) hs_first = int'(o_HCNTR);
               hs_len++;
            end
            if (o_VCNTR == 0 && o_HBLANK_n) hb_len++;
            if (o_HCNTR == 0 && !o_VSYNC_n) begin
               if (vs_len == 0) vs_first = int'(o_VCNTR);
               vs_len++;
            end
            if (o_HCNTR == 0 && o_VBLANK_n) vb_len++;
         end
      end while (!o_FRAME_START && per < 4000);
   endtask

   task automatic next_px();
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!o_PXCEN && c < 20);
      if (!o_PXCEN) chk("px_timeout", 0, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pxcen"}, int'(o_PXCEN), 0);
      chk({tag, "_hcnt"}, int'(o_HCNTR), 0);
      chk({tag, "_vcnt"}, int'(o_VCNTR), 0);
      chk({tag, "_hsync_n"}, int'(o_HSYNC_n), 1);
      chk({tag, "_vsync_n"}, int'(o_VSYNC_n), 1);
      chk({tag, "_hblank_n"}, int'(o_HBLANK_n), 0);
      chk({tag, "_vblank_n"}, int'(o_VBLANK_n), 0);
      chk({tag, "_fstart"}, int'(o_FRAME_START), 0);
   endtask

   // counts MCLKs from reset release to the first pixel enable and then to the first frame start
   task automatic release_and_time(input string tag);
      rst_n = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_hcnt_rel"}, int'(o_HCNTR), 0);
      end while (!o_PXCEN && n < 50);
      chk({tag, "_first_px"}, n, 3);
      chk({tag, "_hcnt_px1"}, int'(o_HCNTR), 1);
      @(negedge clk);
      chk({tag, "_px_width"}, int'(o_PXCEN), 0);
      m = 1;
      do begin
         @(negedge clk);
         m++;
      end while (!o_PXCEN && m < 50);
      chk({tag, "_px_period"}, m, 3);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!o_FRAME_START && k < 4000);
      chk({tag, "_first_frame"}, n + m + k, 1056);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset("rst");
      release_and_time("boot");

      // mode 0 frame
      scan();
      chk("a_period", per, 1056);
      chk("a_hmax", hmax, 15);
      chk("a_vmax", vmax, 21);
      chk("a_hs_first", hs_first, 10);
      chk("a_hs_len", hs_len, 2);
      chk("a_hb_len", hb_len, 8);
      chk("a_vs_first", vs_first, 12);
      chk("a_vs_len", vs_len, 2);
      chk("a_vb_len", vb_len, 4);

      // NTSC request mid-frame: this frame keeps the original height
      fork
         scan();
         begin repeat (200) @(negedge clk); mode = 2'd1; end
      join
      chk("b_period", per, 1056);
      chk("b_vmax", vmax, 21);

      fork
         scan();
         begin repeat (200) @(negedge clk); vpos = 4'd1; end
      join
      chk("c_period", per, 1008);
      chk("c_vmax", vmax, 20);
      chk("c_vs_first", vs_first, 12);

      fork
         scan();
         begin repeat (200) @(negedge clk); mode = 2'd2; adj_h = 2'd3; adj_v = 3'd5; vpos = 4'd15; end
      join
      chk("d_period", per, 1008);
      chk("d_vs_first", vs_first, 5);
      chk("d_vs_len", vs_len, 2);

      fork
         scan();
         begin repeat (200) @(negedge clk); mode = 2'd3; vpos = 4'd0; end
      join
      chk("e_period", per, 1782);
      chk("e_hmax", hmax, 21);
      chk("e_vmax", vmax, 26);
      chk("e_hs_first", hs_first, 10);
      chk("e_hb_len", hb_len, 8);
      chk("e_vs_first", vs_first, 19);
      chk("e_vs_len", vs_len, 2);
      chk("e_vb_len", vb_len, 4);

      // reserved mode behaves as original even with custom extensions applied
      fork
         scan();
         begin repeat (200) @(negedge clk); flip = 1'b1; end
      join
      chk("f_period", per, 1056);
      chk("f_hmax", hmax, 15);
      chk("f_vs_first", vs_first, 12);
      chk("g_flip_h00", int'(o_HCNTR), 7);
      chk("g_flip_v00", int'(o_VCNTR), 3);

      next_px();
      chk("g_flip_h01", int'(o_HCNTR), 6);
      chk("g_flip_v01", int'(o_VCNTR), 3);
      repeat (11) next_px();
      chk("g_raw_h12", int'(o_HCNTR), 12);
      chk("g_raw_v12", int'(o_VCNTR), 0);

      k = 0;
      while (!(o_VCNTR == 12 && o_HCNTR == 0) && k < 2000) begin
         next_px();
         k++;
      end
      chk("pre_rst_vsync_n", int'(o_VSYNC_n), 0);
      chk("pre_rst_hblank_n", int'(o_HBLANK_n), 1);
      rst_n = 1'b0;
      #1;
      chk_reset("mid_rst");
      mode = 2'd1;
      repeat (2) @(negedge clk);
      release_and_time("rerun");
      chk("rerun_flip_h00", int'(o_HCNTR), 7);
      chk("rerun_flip_v00", int'(o_VCNTR), 3);
      scan();
      chk("rerun_period", per, 1008);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
